// File: rtl/seg_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each SEG-bit carry-chain slice has its own
// stage, the carry is registered between stages, and a valid/ready handshake stalls the whole pipe.
module seg_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int SEG    = 4,
  parameter int STAGES = WIDTH / SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LAST = STAGES - 1;

  // a/b hold the not-yet-added high segments (skew), s the finished low segments (deskew).
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  logic adv;

  // The pipe moves as a unit: it advances whenever the output slot is empty or being drained.
  assign adv      = !v_q[LAST] | out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the conditioned operands, later stages their predecessor.
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub | cin;
    s_in[0] = '0;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  // NOTE: every variable here is assigned on every pass before it is read, so no latch can form.
  always_comb begin
    logic [SEG:0] slice;
    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, c_in[k]};
      a_d[k]               = a_in[k];
      b_d[k]               = b_in[k];
      s_d[k]               = s_in[k];
      s_d[k][k*SEG +: SEG] = slice[SEG-1:0];
      c_d[k]               = slice[SEG];
      v_d[k]               = v_in[k];
    end
    // a^b^s at the MSB recovers the carry into the MSB without a second adder.
    ovf_d = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
  end

  // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value.
  // These arrays are pipeline flops rather than RAM, so clearing them in reset is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder (WIDTH=16, SEG=4, latency 4): latency, carries,
// subtract, streaming under backpressure, bubbles and asynchronous reset mid-flight.
module tb_seg_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  seg_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed stream: a, b, cin, sub and hand-computed sum/cout/ovf.
  logic [15:0] va [8] = '{16'h0001, 16'h00FF, 16'h1000, 16'h8000, 16'h0010, 16'h0000, 16'h7FFF, 16'hABCD};
  logic [15:0] vb [8] = '{16'h0001, 16'h0001, 16'h2000, 16'h8000, 16'h0010, 16'h0001, 16'hFFFF, 16'h1111};
  logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] es [8] = '{16'h0002, 16'h0100, 16'h3001, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'hBCDF};
  logic        ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v);
    in_valid = v;
    a        = va[i];
    b        = vb[i];
    cin      = vc[i];
    sub      = vs[i];
  endtask

  // Issue one beat into an idle pipe and measure edges until out_valid.
  task automatic one_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tcin, input logic tsub,
                          input logic [15:0] xs, input logic xc, input logic xo);
    int lat;
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      cyc();
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, xs);
    check({tag, "_cout"}, cout, xc);
    check({tag, "_ovf"}, ovf, xo);
    cyc();
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_in, n_out, hold_left;
    logic hold_done, acc, ret;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    one_beat("basic",     16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    one_beat("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_beat("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one_beat("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one_beat("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Streaming: 8 back-to-back beats, out_ready held low 3 cycles at the first result.
    n_in = 0; n_out = 0; hold_left = 0; hold_done = 1'b0;
    for (int t = 0; t < 40 && n_out < 8; t++) begin
      if (out_valid && !hold_done) begin
        hold_done = 1'b1;
        hold_left = 3;
      end
      out_ready = (hold_left == 0);
      if (n_in < 8) drive(n_in, 1'b1);
      else in_valid = 1'b0;
      #1;
      if (hold_left > 0) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_sum", sum, es[n_out]);
        check("stall_cout", cout, ec[n_out]);
        check("stall_ovf", ovf, eo[n_out]);
        hold_left--;
      end
      acc = in_valid & in_ready;
      ret = out_valid & out_ready;
      if (ret) begin
        check($sformatf("stream_sum_%0d", n_out), sum, es[n_out]);
        check($sformatf("stream_cout_%0d", n_out), cout, ec[n_out]);
        check($sformatf("stream_ovf_%0d", n_out), ovf, eo[n_out]);
        n_out++;
      end
      if (acc) n_in++;
      cyc();
    end
    check("stream_results", n_out, 8);
    check("stream_accepted", n_in, 8);
    check("stream_hold_seen", hold_done, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 6; t++) cyc();

    // Bubbles: in_valid 1,0,1,0,1,0; results expected after edges 4,6,8.
    for (int e = 1; e <= 9; e++) begin
      if (e <= 6) drive((e - 1) / 2, ((e - 1) % 2) == 0);
      else in_valid = 1'b0;
      cyc();
      if (e >= 4) begin
        check($sformatf("bubble_valid_e%0d", e), out_valid, ((e - 4) % 2) == 0);
        if (((e - 4) % 2) == 0) check($sformatf("bubble_sum_e%0d", e), sum, es[(e - 4) / 2]);
      end
    end

    // Reset mid-flight: one result at the output, three more in flight.
    a = 16'h8000; b = 16'h8001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    cyc();
    for (int i = 1; i < 4; i++) begin
      drive(i, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sum", sum, 16'h0001);
    check("pre_rst_cout", cout, 1);
    check("pre_rst_ovf", ovf, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    check("async_rst_ovf", ovf, 0);
    check("async_rst_in_ready", in_ready, 1);
    cyc();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      cyc();
      check($sformatf("no_stale_%0d", t), out_valid, 0);
    end
    one_beat("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
